l2_bank_resp_router: RTL

- Per-bank response stage of the L2 crossbar, sitting directly upstream of each master's response tree.
- Records which master's request the bank accepted and tracks it through the fixed SRAM read latency.
- Returns the bank read data as a one-hot per-master valid plus a zero-gated data bus, which feed the per-master response-tree inputs.
- One instance per L2 bank.

---
 rtl/l2_xbar_pkg.sv | 20 ++
 rtl/l2_resp_track_pipe.sv | 30 +++
 rtl/l2_bank_resp_router.sv | 134 +++++++++++++
 3 files changed

// File: rtl/l2_xbar_pkg.sv
// Shared L2 crossbar types: the per-request tracking record carried through
// the bank read-latency pipeline, plus crossbar-wide limits.
package l2_xbar_pkg;

    localparam int MAX_MEM_LATENCY = 4;

    // Wide enough for any supported master count (up to 256 masters).
    localparam int TRACK_ID_WIDTH = 8;

    typedef struct packed {
        logic                      valid;
        logic [TRACK_ID_WIDTH-1:0] id;
        logic                      wen;
    } resp_track_t;

    function automatic logic [TRACK_ID_WIDTH-1:0] to_track_id(input int unsigned id);
        return id[TRACK_ID_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/l2_resp_track_pipe.sv
// Fixed-depth shift register of resp_track_t records, advancing every cycle.
// Reset clears only the valid bits; id/wen payload is don't-care when invalid.
module l2_resp_track_pipe
    import l2_xbar_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  resp_track_t track_d,
    output resp_track_t track_q
);

    resp_track_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        stage_q[0] <= track_d;
        for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
        end
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i].valid <= 1'b0;
            end
        end
    end

    assign track_q = stage_q[DEPTH-1];

endmodule

// File: rtl/l2_bank_resp_router.sv
// Per-bank response router: tracks accepted requests through the SRAM latency
// and returns one-hot valid plus zero-gated data. Optional output register: L2_RESP_OUT_REG_EN.
module l2_bank_resp_router
    import l2_xbar_pkg::*;
#(
    parameter int N_MASTER    = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int MEM_LATENCY = 1,
    parameter int ID_WIDTH    = $clog2(N_MASTER),
    parameter int CNT_WIDTH   = $clog2(MEM_LATENCY + 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_req_i,
    input  logic                  data_gnt_i,
    input  logic [ID_WIDTH-1:0]   data_ID_i,
    input  logic                  data_wen_i,
    input  logic [DATA_WIDTH-1:0] bank_rdata_i,
    output logic [N_MASTER-1:0]   data_r_valid_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic [CNT_WIDTH-1:0]  inflight_o,
    output logic                  id_err_o
);

`ifdef L2_RESP_OUT_REG_EN
    localparam int OUT_STAGES = 1;
`else
    localparam int OUT_STAGES = 0;
`endif
    localparam int MAX_INFLIGHT = MEM_LATENCY + OUT_STAGES;
    localparam logic [ID_WIDTH:0] N_MASTER_W = (ID_WIDTH + 1)'(N_MASTER);

    if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_MEM_LATENCY || N_MASTER < 2 ||
        ID_WIDTH > TRACK_ID_WIDTH) begin : g_param_check
        $error("l2_bank_resp_router: unsupported parameter combination");
    end

    logic        accept;
    logic        id_legal;
    logic        id_err_q;
    resp_track_t track_in;
    resp_track_t last_stage;

    assign accept   = data_req_i & data_gnt_i;
    assign id_legal = ({1'b0, data_ID_i} < N_MASTER_W);

    always_comb begin
        track_in       = '0;
        track_in.valid = accept & id_legal;
        track_in.id    = TRACK_ID_WIDTH'(data_ID_i);
        track_in.wen   = data_wen_i;
    end

    l2_resp_track_pipe #(
        .DEPTH   (MEM_LATENCY)
    ) u_track_pipe (
        .clk     (clk),
        .rst     (rst),
        .track_d (track_in),
        .track_q (last_stage)
    );

    // Illegal IDs never enter the pipeline; they only raise a one-cycle flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_err_q <= 1'b0;
        end else begin
            id_err_q <= accept & ~id_legal;
        end
    end

    assign id_err_o = id_err_q;

    logic [N_MASTER-1:0]   resp_valid_c;
    logic [DATA_WIDTH-1:0] resp_rdata_c;

    // Data is zeroed whenever no read response is present so trees can OR it.
    always_comb begin
        resp_valid_c = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            resp_valid_c[i] = last_stage.valid && (last_stage.id == to_track_id(i));
        end
        resp_rdata_c = (last_stage.valid && !last_stage.wen) ? bank_rdata_i : '0;
    end

    logic resp_fire;

`ifdef L2_RESP_OUT_REG_EN
    logic [N_MASTER-1:0]   resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= resp_valid_c;
            resp_rdata_q <= resp_rdata_c;
        end
    end

    assign data_r_valid_o = resp_valid_q;
    assign data_r_rdata_o = resp_rdata_q;
    assign resp_fire      = |resp_valid_q;
`else
    assign data_r_valid_o = resp_valid_c;
    assign data_r_rdata_o = resp_rdata_c;
    assign resp_fire      = last_stage.valid;
`endif

    logic [CNT_WIDTH-1:0] inflight_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            case ({track_in.valid, resp_fire})
                2'b10:   inflight_q <= inflight_q + CNT_WIDTH'(1);
                2'b01:   inflight_q <= inflight_q - CNT_WIDTH'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign inflight_o = inflight_q;

    // The pipeline depth bounds occupancy, so the counter can never pass it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (inflight_q <= CNT_WIDTH'(MAX_INFLIGHT));
        end
    end

endmodule
